// File: rtl/axis_mc_pkg.sv
// Shared types and helpers for the AXI-Stream multicast replicator.
package axis_mc_pkg;

    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } state_e;

    localparam int unsigned MODE_BLOCKING = 0;
    localparam int unsigned MODE_DROP     = 1;

    // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_mc_fifo.sv
// Per-replica first-word fall-through FIFO carrying {tlast, tkeep, tdata}.
module axis_mc_fifo
    import axis_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [OCC_W-1:0] free_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign free_o  = OCC_W'(DEPTH) - count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + OCC_W'(do_push) - OCC_W'(do_pop);
        end
    end

    // Storage has no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axis_multicast_replicator.sv
// Replicates each input packet to a per-packet subset of outputs, with blocking or drop policy.
module axis_multicast_replicator
    import axis_mc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned IF_STREAM     = 1,
    parameter int unsigned KEEP_WIDTH    = (IF_STREAM != 0) ? DATA_WIDTH / 8 : 1,
    parameter int unsigned REPLICA_COUNT = 4,
    parameter int unsigned FIFO_DEPTH    = 64,
    parameter int unsigned DROP_MODE     = 0,
    parameter int unsigned MAX_PKT_BEATS = 24,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_WIDTH-1:0]              s_axis_in_tdata,
    input  logic [KEEP_WIDTH-1:0]              s_axis_in_tkeep,
    input  logic                               s_axis_in_tvalid,
    input  logic                               s_axis_in_tlast,
    input  logic [REPLICA_COUNT-1:0]           s_axis_in_tmask,
    output logic                               s_axis_in_tready,
    input  logic [REPLICA_COUNT-1:0]           replica_enable,
    output logic [REPLICA_COUNT*DATA_WIDTH-1:0] m_axis_out_tdata,
    output logic [REPLICA_COUNT*KEEP_WIDTH-1:0] m_axis_out_tkeep,
    output logic [REPLICA_COUNT-1:0]           m_axis_out_tvalid,
    output logic [REPLICA_COUNT-1:0]           m_axis_out_tlast,
    input  logic [REPLICA_COUNT-1:0]           m_axis_out_tready,
    output logic [REPLICA_COUNT*CNT_WIDTH-1:0] drop_count
);

    localparam int unsigned OCC_W  = occ_width(FIFO_DEPTH);
    localparam int unsigned BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

    state_e                                   state_q, state_d;
    logic [REPLICA_COUNT-1:0]                 mask_q, mask_d;
    logic [REPLICA_COUNT-1:0][CNT_WIDTH-1:0]  drop_q, drop_d;
    logic [REPLICA_COUNT-1:0]                 cand;
    logic [REPLICA_COUNT-1:0]                 eff;
    logic [REPLICA_COUNT-1:0]                 space_ok;
    logic [REPLICA_COUNT-1:0]                 drop_inc;
    logic [REPLICA_COUNT-1:0]                 full;
    logic [REPLICA_COUNT-1:0]                 empty;
    logic [OCC_W-1:0]                         free [REPLICA_COUNT];
    logic [KEEP_WIDTH-1:0]                    in_keep;
    logic                                     in_last;
    logic                                     ready;
    logic                                     hs;
    logic [BEAT_W-1:0]                        wr_beat;

    // Message mode turns every beat into a complete single-beat packet.
    assign in_keep = (IF_STREAM != 0) ? s_axis_in_tkeep : '1;
    assign in_last = (IF_STREAM != 0) ? s_axis_in_tlast : 1'b1;
    assign wr_beat = {in_last, in_keep, s_axis_in_tdata};

    always_comb begin
        for (int r = 0; r < REPLICA_COUNT; r++) begin
            space_ok[r] = (free[r] >= OCC_W'(MAX_PKT_BEATS));
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        drop_d   = drop_q;
        drop_inc = '0;
        cand     = s_axis_in_tmask & replica_enable;
        eff      = mask_q;
        if (state_q == HEAD) begin
            eff = (DROP_MODE == MODE_DROP) ? (cand & space_ok) : cand;
        end
        // Ready looks only at registered full flags, never at downstream tready.
        ready = rst_n & (&(~eff | ~full));
        hs    = s_axis_in_tvalid & ready;
        if (hs) begin
            if (state_q == HEAD) begin
                if (DROP_MODE == MODE_DROP) drop_inc = cand & ~space_ok;
                if (!in_last) begin
                    state_d = BODY;
                    mask_d  = eff;
                end
            end else if (in_last) begin
                state_d = HEAD;
            end
        end
        for (int r = 0; r < REPLICA_COUNT; r++) begin
            if (drop_inc[r] && (drop_q[r] != '1)) drop_d[r] = drop_q[r] + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HEAD;
            mask_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            drop_q  <= drop_d;
        end
    end

    assign s_axis_in_tready = ready;
    assign drop_count       = drop_q;

    for (genvar r = 0; r < REPLICA_COUNT; r++) begin : g_rep
        logic [BEAT_W-1:0] rd_beat;

        axis_mc_fifo #(
            .WIDTH (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (hs & eff[r]),
            .data_i  (wr_beat),
            .pop_i   (m_axis_out_tvalid[r] & m_axis_out_tready[r]),
            .data_o  (rd_beat),
            .full_o  (full[r]),
            .empty_o (empty[r]),
            .free_o  (free[r])
        );

        assign m_axis_out_tvalid[r]                          = ~empty[r];
        assign m_axis_out_tdata[r*DATA_WIDTH +: DATA_WIDTH]  = rd_beat[DATA_WIDTH-1:0];
        assign m_axis_out_tkeep[r*KEEP_WIDTH +: KEEP_WIDTH]  = rd_beat[DATA_WIDTH +: KEEP_WIDTH];
        assign m_axis_out_tlast[r]                           = rd_beat[BEAT_W-1];
    end

endmodule

// File: tb/tb_axis_multicast_replicator.sv
// Scoreboard bench: a blocking instance (A, depth 4) and a drop instance (B, depth 8, reserve 4).
module tb_axis_multicast_replicator;

    typedef logic [36:0] beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic [3:0]  tmask;
    logic [3:0]  enable;
    logic        tvalid_a, tvalid_b;
    logic        tready_a, tready_b;
    logic [127:0] odata_a, odata_b;
    logic [15:0] okeep_a, okeep_b;
    logic [3:0]  ovalid_a, ovalid_b, olast_a, olast_b;
    logic [3:0]  mready_a, mready_b;
    logic [7:0]  drop_a, drop_b;

    beat_t exp_q [8][$];
    bit [7:0] seen_valid;
    bit       in_hs;
    bit       sel_b;
    int       checks = 0;
    int       errors = 0;
    int       st, tot;

    always #5 clk = ~clk;

    axis_multicast_replicator #(
        .DATA_WIDTH(32), .IF_STREAM(1), .KEEP_WIDTH(4), .REPLICA_COUNT(4),
        .FIFO_DEPTH(4), .DROP_MODE(0), .MAX_PKT_BEATS(4), .CNT_WIDTH(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_in_tdata(tdata), .s_axis_in_tkeep(tkeep), .s_axis_in_tvalid(tvalid_a),
        .s_axis_in_tlast(tlast), .s_axis_in_tmask(tmask), .s_axis_in_tready(tready_a),
        .replica_enable(enable),
        .m_axis_out_tdata(odata_a), .m_axis_out_tkeep(okeep_a), .m_axis_out_tvalid(ovalid_a),
        .m_axis_out_tlast(olast_a), .m_axis_out_tready(mready_a), .drop_count(drop_a)
    );

    axis_multicast_replicator #(
        .DATA_WIDTH(32), .IF_STREAM(1), .KEEP_WIDTH(4), .REPLICA_COUNT(4),
        .FIFO_DEPTH(8), .DROP_MODE(1), .MAX_PKT_BEATS(4), .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_in_tdata(tdata), .s_axis_in_tkeep(tkeep), .s_axis_in_tvalid(tvalid_b),
        .s_axis_in_tlast(tlast), .s_axis_in_tmask(tmask), .s_axis_in_tready(tready_b),
        .replica_enable(enable),
        .m_axis_out_tdata(odata_b), .m_axis_out_tkeep(okeep_b), .m_axis_out_tvalid(ovalid_b),
        .m_axis_out_tlast(olast_b), .m_axis_out_tready(mready_b), .drop_count(drop_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Output handshakes are sampled on the falling edge and popped against the scoreboard.
    task automatic score();
        for (int s = 0; s < 8; s++) begin
            int    r;
            logic  v, rd, ok;
            beat_t got, want;
            r = s % 4;
            if (s < 4) begin
                v = ovalid_a[r]; rd = mready_a[r];
                got = {olast_a[r], okeep_a[r*4 +: 4], odata_a[r*32 +: 32]};
            end else begin
                v = ovalid_b[r]; rd = mready_b[r];
                got = {olast_b[r], okeep_b[r*4 +: 4], odata_b[r*32 +: 32]};
            end
            if (v) seen_valid[s] = 1'b1;
            if (v && rd) begin
                checks++;
                ok   = (exp_q[s].size() != 0);
                want = '0;
                if (ok) want = exp_q[s].pop_front();
                assert (ok && got === want) else begin
                    errors++;
                    $error("FAIL beat stream=%0d observed=%h expected=%h queued=%0d", s, got, want, ok);
                end
            end
        end
        in_hs = sel_b ? (tvalid_b & tready_b) : (tvalid_a & tready_a);
    endtask

    task automatic tick();
        @(negedge clk);
        score();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int dut, input logic [31:0] d, input logic [3:0] k, input bit last,
                             input logic [3:0] m, input logic [3:0] dst, output int stalls);
        tdata = d; tkeep = k; tlast = last; tmask = m;
        sel_b = (dut != 0);
        if (dut != 0) tvalid_b = 1'b1; else tvalid_a = 1'b1;
        stalls = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (in_hs) break;
            stalls++;
        end
        check("accept_timeout", 64'(in_hs), 64'd1);
        for (int r = 0; r < 4; r++) begin
            if (dst[r]) exp_q[dut*4 + r].push_back({last, k, d});
        end
    endtask

    task automatic send_pkt(input int dut, input logic [31:0] base, input int n, input logic [3:0] mh,
                            input logic [3:0] mb, input logic [3:0] dst, input logic [3:0] keep_last,
                            output int stalls);
        int s1;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            send_beat(dut, base + 32'(i), (i == n - 1) ? keep_last : 4'hf, (i == n - 1),
                      (i == 0) ? mh : mb, dst, s1);
            stalls += s1;
        end
        tvalid_a = 1'b0;
        tvalid_b = 1'b0;
    endtask

    function automatic int qsum(input int base);
        int n = 0;
        for (int s = base; s < base + 4; s++) n += exp_q[s].size();
        return n;
    endfunction

    initial begin
        rst_n = 1'b0; tvalid_a = 1'b0; tvalid_b = 1'b0;
        tdata = '0; tkeep = '0; tlast = 1'b0; tmask = '0; enable = 4'hf;
        mready_a = 4'hf; mready_b = 4'hf; sel_b = 1'b0;
        repeat (3) tick();
        check("rst_tready", 64'({tready_a, tready_b}), 64'd0);
        check("rst_valid", 64'({ovalid_a, ovalid_b}), 64'd0);
        check("rst_drop", 64'({drop_a, drop_b}), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_tready", 64'({tready_a, tready_b}), 64'h3);

        // Broadcast three beats to all outputs
        send_pkt(0, 32'hA0, 3, 4'hf, 4'hf, 4'hf, 4'h3, st);
        check("bcast_stall", 64'(st), 64'd0);
        tick();
        check("bcast_drain", 64'(qsum(0)), 64'd0);

        // Selective multicast; body-beat mask change must not redirect the packet
        seen_valid = '0;
        send_pkt(0, 32'hB0, 2, 4'b0101, 4'b1010, 4'b0101, 4'hf, st);
        send_pkt(0, 32'hC0, 2, 4'b0010, 4'b0010, 4'b0010, 4'h1, st);
        repeat (2) tick();
        check("sel_drain", 64'(qsum(0)), 64'd0);
        check("sel_seen", 64'(seen_valid[3:0]), 64'h7);

        // Backpressure on replica 1 of the depth-4 blocking instance
        mready_a = 4'b1101;
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(0, 32'hD0 + 32'(i), 4'hf, 1'b0, 4'b0011, 4'b0011, st);
            tot += st;
        end
        check("bp_first4_stall", 64'(tot), 64'd0);
        tdata = 32'hD4; tlast = 1'b0; tvalid_a = 1'b1;
        tick();
        check("bp_ready_low0", 64'(in_hs), 64'd0);
        tick();
        check("bp_ready_low1", 64'(in_hs), 64'd0);
        mready_a = 4'hf;
        send_beat(0, 32'hD4, 4'hf, 1'b0, 4'b0011, 4'b0011, st);
        send_beat(0, 32'hD5, 4'h7, 1'b1, 4'b0011, 4'b0011, st);
        tvalid_a = 1'b0;
        repeat (6) tick();
        check("bp_drain", 64'(qsum(0)), 64'd0);

        // Drop policy with stalled replica 2, then drop counter saturation
        mready_b = 4'b1011;
        tot = 0;
        send_pkt(1, 32'h100, 4, 4'b0100, 4'b0100, 4'b0100, 4'hf, st); tot += st;
        send_pkt(1, 32'h110, 4, 4'b0100, 4'b0100, 4'b0100, 4'hf, st); tot += st;
        check("drop_none_yet", 64'(drop_b), 64'd0);
        send_pkt(1, 32'h120, 4, 4'b0100, 4'b0100, 4'b0000, 4'hf, st); tot += st;
        check("drop_first", 64'(drop_b[5:4]), 64'd1);
        send_pkt(1, 32'h130, 4, 4'b0100, 4'b0100, 4'b0000, 4'hf, st); tot += st;
        send_pkt(1, 32'h140, 4, 4'b0100, 4'b0100, 4'b0000, 4'hf, st); tot += st;
        check("drop_three", 64'(drop_b[5:4]), 64'd3);
        check("drop_no_stall", 64'(tot), 64'd0);
        send_pkt(1, 32'h150, 4, 4'b0100, 4'b0100, 4'b0000, 4'hf, st);
        send_pkt(1, 32'h160, 4, 4'b0100, 4'b0100, 4'b0000, 4'hf, st);
        check("drop_saturate", 64'(drop_b[5:4]), 64'd3);
        check("drop_others", 64'(drop_b & 8'hcf), 64'd0);
        check("blocking_no_drop", 64'(drop_a), 64'd0);
        mready_b = 4'hf;
        repeat (10) tick();
        check("drop_drain", 64'(qsum(4)), 64'd0);

        // Empty destination mask swallows the packet
        sel_b = 1'b0;
        seen_valid = '0;
        send_pkt(0, 32'h200, 2, 4'b0000, 4'b0000, 4'b0000, 4'hf, st);
        check("mask0_stall", 64'(st), 64'd0);
        repeat (3) tick();
        check("mask0_no_valid", 64'(seen_valid[3:0]), 64'd0);

        // Reset in the middle of a packet, then a clean packet
        mready_a = 4'h0;
        send_beat(0, 32'h300, 4'hf, 1'b0, 4'hf, 4'hf, st);
        send_beat(0, 32'h301, 4'hf, 1'b0, 4'hf, 4'hf, st);
        tvalid_a = 1'b0;
        tick();
        check("mid_queued", 64'(ovalid_a), 64'hf);
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 64'({ovalid_a, ovalid_b}), 64'd0);
        check("mid_rst_drop", 64'(drop_b), 64'd0);
        for (int s = 0; s < 8; s++) exp_q[s].delete();
        rst_n = 1'b1;
        mready_a = 4'hf;
        tick();
        send_pkt(0, 32'h310, 2, 4'b1001, 4'b1001, 4'b1001, 4'h7, st);
        check("post_rst_stall", 64'(st), 64'd0);
        repeat (3) tick();
        check("post_rst_drain", 64'(qsum(0)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_multicast_replicator.md
Name: axis_multicast_replicator

Overview:
- Parametrised multicast successor to the broadcast replicator.
- Takes one AXI-Stream input and replicates each packet to a per-packet subset of REPLICA_COUNT outputs. The subset comes from a destination mask sampled on the first beat.
- Each output has its own FIFO.
- Selectable policy for slow consumers: lock-step backpressure (BLOCKING) or per-replica whole-packet drop (DROP) with saturating drop counters.
- Sits between an event/packet source and several independent handler pipelines.

Parameters:
- DATA_WIDTH, 512, data bits per beat.
- IF_STREAM, 1. 1: multi-beat packets using tkeep/tlast. 0: every beat is a complete message.
- KEEP_WIDTH, IF_STREAM ? DATA_WIDTH/8 : 1, tkeep width.
- REPLICA_COUNT, 4, number of outputs, 1..16.
- FIFO_DEPTH, 64, beats per output FIFO; power of two, ≥ 2.
- DROP_MODE, 0. 0 = BLOCKING, 1 = DROP.
- MAX_PKT_BEATS, 24, space reserved per packet in DROP mode; must be ≤ FIFO_DEPTH.
- CNT_WIDTH, 32, drop counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- s_axis_in_tdata  in  DATA_WIDTH  input data
- s_axis_in_tkeep  in  KEEP_WIDTH  input keep; ignored when IF_STREAM=0
- s_axis_in_tvalid  in  1  input valid
- s_axis_in_tlast  in  1  input last; ignored when IF_STREAM=0
- s_axis_in_tmask  in  REPLICA_COUNT  destination mask; sampled on the first beat only
- s_axis_in_tready  out  1  input ready
- replica_enable  in  REPLICA_COUNT  static per-output enable; sampled on the first beat
- m_axis_out_tdata  out  REPLICA_COUNT*DATA_WIDTH  output data; replica r at [r*DATA_WIDTH +: DATA_WIDTH]
- m_axis_out_tkeep  out  REPLICA_COUNT*KEEP_WIDTH  output keep
- m_axis_out_tvalid  out  REPLICA_COUNT  output valid
- m_axis_out_tlast  out  REPLICA_COUNT  output last
- m_axis_out_tready  in  REPLICA_COUNT  output ready
- drop_count  out  REPLICA_COUNT*CNT_WIDTH  packets dropped per replica

Behaviour:
- Reset:
  - One clock clk; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
  - While rst_n=0: state HEAD, all FIFOs empty, m_axis_out_tvalid=0, drop_count=0, s_axis_in_tready=0.
  - Reset mid-packet discards all partial packets, queued and in flight.
- IF_STREAM=0: tkeep is forced all-ones and tlast is forced 1, so every beat is a HEAD beat.
- Input FSM, states HEAD and BODY:
  - HEAD: cand = s_axis_in_tmask & replica_enable.
    - BLOCKING: eff = cand.
    - DROP: eff = cand & space_ok, where space_ok[r] = (free[r] ≥ MAX_PKT_BEATS). Every r in cand & ~space_ok increments drop_count[r] once, at the handshake.
  - A HEAD handshake with tlast=0 latches eff into mask_q and moves to BODY.
  - BODY: eff = mask_q. A handshake with tlast=1 returns to HEAD.
  - A HEAD handshake with tlast=1 stays in HEAD (single-beat packet).
- Ready: s_axis_in_tready = rst_n & AND over r of (~eff[r] | ~full[r]).
  - Derived from registered full flags only; no combinational path from m_axis_out_tready.
  - A FIFO that is full and read in the same cycle still deasserts ready for that cycle.
- Write: on handshake, the beat {tdata, tkeep, tlast} is pushed into FIFO r for every r with eff[r]=1.
- Empty destination: if eff is all-zero, the whole packet is accepted and discarded with ready held at 1. It is still tracked through HEAD/BODY.
- DROP reservation:
  - Guarantees no stall for packets ≤ MAX_PKT_BEATS.
  - Longer packets fall back to backpressure through the full flag and are never truncated.
- Outputs:
  - Each FIFO drives its port in standard AXIS form with first-word fall-through.
  - A beat accepted at edge N is valid on its output from cycle N+1.
  - tvalid, once asserted, holds until tready.
  - Throughput is one beat per cycle per FIFO, with simultaneous push and pop allowed.
- Counters: FIFO occupancy is log2(FIFO_DEPTH)+1 bits wide. drop_count saturates at 2^CNT_WIDTH-1 and never wraps.
- Mask and enable changes: changes to replica_enable or s_axis_in_tmask mid-packet have no effect until the next HEAD.
- Ordering: per-replica beat order equals input order, and packets are never interleaved.

Decomposition:
- Package axis_mc_pkg:
  - enum state_e {HEAD, BODY}
  - constants MODE_BLOCKING=0, MODE_DROP=1
  - function clog2-based occupancy width
- Sub-module axis_mc_fifo: one instance per replica.
  - Synchronous first-word fall-through FIFO with full, empty and free-count outputs.
  - Carries tdata, tkeep and tlast.
  - Synchronous active-low reset.

Test Plan:
- Broadcast: BLOCKING, mask=4'b1111, enable all, 3-beat packet A0..A2; all m_tready=1 → each output shows A0, A1, A2 in cycles N+1..N+3, with tlast only on A2.
- Selective multicast: mask=4'b0101, 2-beat packet; then mask=4'b0010 → output 0 and output 2 get packet 1 only, output 1 gets packet 2 only, output 3 never asserts tvalid.
- Backpressure: BLOCKING, FIFO_DEPTH=4, mask=4'b0011, m_tready[1]=0, 6-beat packet → s_tready drops after 4 accepted beats; releasing m_tready[1] completes the transfer with all 6 beats in order on both outputs.
- Drop: DROP_MODE=1, MAX_PKT_BEATS=4, FIFO_DEPTH=8, m_tready[2]=0; send five 4-beat packets to mask 4'b0100 → packets 1-2 queued (free falls 8→4→0), packets 3-5 dropped, drop_count[2]=3, s_tready never deasserts.
- Edge cases:
  - Mask=0 → packet swallowed with tready=1 and no output valid.
  - Asserting rst_n=0 mid-BODY → all tvalid=0 and drop_count=0 next cycle; the following packet is delivered cleanly.
- Saturation: CNT_WIDTH=2, force 5 drops on one replica → drop_count holds 3.
